// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory-op and FSM encodings plus
// small classification helpers used by the stage and its lane-steering logic.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Loads and stores occupy contiguous encoding ranges.
  localparam logic [3:0] LOAD_FIRST  = 4'd1;
  localparam logic [3:0] LOAD_LAST   = 4'd5;
  localparam logic [3:0] STORE_FIRST = 4'd6;
  localparam logic [3:0] STORE_LAST  = 4'd8;

  localparam int TIMEOUT_W = 8;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= LOAD_FIRST) && (op <= LOAD_LAST);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= STORE_FIRST) && (op <= STORE_LAST);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    logic bad;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: bad = a[0];
      MEM_LW, MEM_SW:          bad = (a != 2'b00);
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store byte enables / replicated write data,
// and load lane selection with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_res
);

  logic [3:0]  byte_hit;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_hit
    assign byte_hit[gi] = (addr_lo == 2'(gi));
  end

  assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    case (op)
      MEM_SB: begin
        be    = byte_hit;
        wdata = {4{rt[7:0]}};
      end
      MEM_SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{rt[15:0]}};
      end
      MEM_SW: begin
        be    = 4'b1111;
        wdata = rt;
      end
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    load_res = 32'h0;
    case (op)
      MEM_LB:  load_res = {{24{lane_byte[7]}}, lane_byte};
      MEM_LBU: load_res = {24'h0, lane_byte};
      MEM_LH:  load_res = {{16{lane_half[15]}}, lane_half};
      MEM_LHU: load_res = {16'h0, lane_half};
      MEM_LW:  load_res = rdata;
      default: load_res = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: single-entry request/grant/response bus master with flush
// and bus timeout. Define MEM_ALIGN_CHECK_EN to trap misaligned halves/words.
module mem_stage
  import mem_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_alu_res,
  input  logic [31:0]           in_rt,
  input  logic [3:0]            in_mem_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  flush,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [3:0]            data_be,
  output logic [31:0]           data_addr,
  output logic [31:0]           data_wdata,
  input  logic                  data_gnt,
  input  logic                  data_rvalid,
  input  logic [31:0]           data_rdata,
  output logic                  out_valid,
  output logic [31:0]           out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_err
);

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e            state_reg;
  mem_op_e               op_reg;
  logic [31:0]           addr_reg;
  logic [31:0]           rt_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic                  kill_reg;
  logic [TIMEOUT_W-1:0]  cnt_reg;
  logic                  out_valid_reg;
  logic [31:0]           out_result_reg;
  logic [REG_ADDR_W-1:0] out_rd_reg;
  logic                  out_err_reg;

  mem_op_e     in_op;
  logic        accept;
  logic        in_is_mem;
  logic        in_misaligned;
  logic        kill_now;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_res;

  assign in_op     = mem_op_e'(in_mem_op);
  assign in_is_mem = is_load(in_mem_op) | is_store(in_mem_op);
  assign in_ready  = (state_reg == ST_IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign kill_now  = kill_reg | flush;

`ifdef MEM_ALIGN_CHECK_EN
  assign in_misaligned = is_misaligned(in_mem_op, in_alu_res[1:0]);
`else
  assign in_misaligned = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .op       (op_reg),
    .addr_lo  (addr_reg[1:0]),
    .rt       (rt_reg),
    .rdata    (data_rdata),
    .be       (lane_be),
    .wdata    (lane_wdata),
    .load_res (load_res)
  );

  // Bus outputs are quiet whenever no request is being presented.
  assign data_req   = (state_reg == ST_REQ) & ~flush;
  assign data_wr    = data_req & is_store(op_reg);
  assign data_be    = data_req ? lane_be : 4'b0000;
  assign data_addr  = data_req ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign data_wdata = data_req ? lane_wdata : 32'h0;

  // Every completion lands in IDLE, so a flush seen alongside the pulse kills it.
  assign out_valid  = out_valid_reg & ~flush;
  assign out_result = out_result_reg;
  assign out_rd     = out_rd_reg;
  assign out_err    = out_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= MEM_NONE;
      addr_reg       <= 32'h0;
      rt_reg         <= 32'h0;
      rd_reg         <= '0;
      kill_reg       <= 1'b0;
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= 32'h0;
      out_rd_reg     <= '0;
      out_err_reg    <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      out_err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg   <= in_op;
            addr_reg <= in_alu_res;
            rt_reg   <= in_rt;
            rd_reg   <= in_rd;
            kill_reg <= 1'b0;
            cnt_reg  <= '0;
            if (in_misaligned) begin
              out_valid_reg  <= 1'b1;
              out_err_reg    <= 1'b1;
              out_result_reg <= in_alu_res;
              out_rd_reg     <= in_rd;
            end else if (in_is_mem) begin
              state_reg <= ST_REQ;
            end else begin
              out_valid_reg  <= 1'b1;
              out_result_reg <= in_alu_res;
              out_rd_reg     <= in_rd;
            end
          end
        end
        ST_REQ: begin
          if (data_gnt) begin
            if (is_load(op_reg)) begin
              // A granted load cannot be recalled; remember the flush instead.
              state_reg <= ST_WAIT;
              cnt_reg   <= '0;
              kill_reg  <= flush;
            end else begin
              state_reg <= ST_IDLE;
              if (!flush) begin
                out_valid_reg  <= 1'b1;
                out_result_reg <= 32'h0;
                out_rd_reg     <= rd_reg;
              end
            end
          end else if (flush) begin
            state_reg <= ST_IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg      <= ST_IDLE;
            out_valid_reg  <= 1'b1;
            out_err_reg    <= 1'b1;
            out_result_reg <= 32'h0;
            out_rd_reg     <= rd_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (data_rvalid) begin
            state_reg <= ST_IDLE;
            if (!kill_now) begin
              out_valid_reg  <= 1'b1;
              out_result_reg <= load_res;
              out_rd_reg     <= rd_reg;
            end
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_IDLE;
            if (!kill_now) begin
              out_valid_reg  <= 1'b1;
              out_err_reg    <= 1'b1;
              out_result_reg <= 32'h0;
              out_rd_reg     <= rd_reg;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (flush) kill_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
